// File: rtl/snake_ctrl.sv
// Snake movement/body controller: steps the head every FRAMES_PER_STEP frames,
// keeps the body in a ring buffer, scans for collisions. Optional: SNAKE_WRAP_EN.
module snake_ctrl #(
  parameter int GRID_SIZE       = 16,
  parameter int FRAME_X_SIZE    = 40,
  parameter int FRAME_Y_SIZE    = 20,
  parameter int FRAME_X_OUTSIDE = 192,
  parameter int FRAME_Y_OUTSIDE = 224,
  parameter int FRAMES_PER_STEP = 8,
  parameter int MAX_LEN         = 16,
  parameter int INIT_LEN        = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        start,
  input  logic [3:0]  dir_in,
  input  logic        dir_valid,
  input  logic        grow,
  input  logic [3:0]  seg_idx,
  output logic [5:0]  seg_col,
  output logic [4:0]  seg_row,
  output logic        seg_valid,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic [4:0]  length,
  output logic        alive,
  output logic        game_over,
  output logic        step_pulse
);

  localparam int AW        = $clog2(MAX_LEN);
  localparam int CNTW      = $clog2(FRAMES_PER_STEP + 1) + 1;
  localparam int START_COL = FRAME_X_SIZE / 2;
  localparam int START_ROW = FRAME_Y_SIZE / 2;
  // one-hot {up, down, left, right}
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_DEAD} state_t;

  // Initial body: head at ring slot 0, trailing cells in the slots behind it.
  function automatic logic [5:0] init_col(input int i);
    int k;
    k = (MAX_LEN - i) % MAX_LEN;
    return (k < INIT_LEN) ? 6'(START_COL - k) : 6'd0;
  endfunction

  function automatic logic [4:0] init_row(input int i);
    int k;
    k = (MAX_LEN - i) % MAX_LEN;
    return (k < INIT_LEN) ? 5'(START_ROW) : 5'd0;
  endfunction

  function automatic logic [10:0] pix_x(input logic [5:0] c);
    return 11'(FRAME_X_OUTSIDE) + 11'(c) * 11'(GRID_SIZE);
  endfunction

  function automatic logic [10:0] pix_y(input logic [4:0] r);
    return 11'(FRAME_Y_OUTSIDE) + 11'(r) * 11'(GRID_SIZE);
  endfunction

  function automatic logic [3:0] rev_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  state_t            state_q, state_d;
  logic              vs_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [3:0]        dir_q, dir_d;
  logic [3:0]        cdir_q, cdir_d;
  logic [3:0]        mdir_q, mdir_d;
  logic [AW-1:0]     head_ptr_q, head_ptr_d;
  logic [4:0]        len_q, len_d;
  logic              pend_q, pend_d;
  logic [4:0]        scan_q, scan_d;
  logic [5:0]        nxt_col_q, nxt_col_d;
  logic [4:0]        nxt_row_q, nxt_row_d;
  logic [10:0]       hx_q, hx_d;
  logic [10:0]       hy_q, hy_d;
  logic              step_q, step_d;
  logic [5:0]        seg_col_q, seg_col_d;
  logic [4:0]        seg_row_q, seg_row_d;
  logic              seg_vld_q, seg_vld_d;
  logic [5:0]        body_col_q [MAX_LEN];
  logic [5:0]        body_col_d [MAX_LEN];
  logic [4:0]        body_row_q [MAX_LEN];
  logic [4:0]        body_row_d [MAX_LEN];

  logic          tick, commit, init, hit, wall, dir_ok, running;
  logic [AW-1:0] wr_ptr, scan_ptr, rd_ptr;
  logic [4:0]    scan_last;
  logic [5:0]    hcol, mv_col;
  logic [4:0]    hrow, mv_row;

  always_comb begin
    tick     = vsync_in & ~vs_q;
    running  = (state_q == S_RUN) || (state_q == S_MOVE) || (state_q == S_CHECK);
    wr_ptr   = head_ptr_q + AW'(1);
    scan_ptr = head_ptr_q - AW'(scan_q);
    rd_ptr   = head_ptr_q - AW'(seg_idx);
    // The tail cell vacates on this move unless growth is pending.
    scan_last = pend_q ? (len_q - 5'd1) : (len_q - 5'd2);
    hit      = (body_col_q[scan_ptr] == nxt_col_q) && (body_row_q[scan_ptr] == nxt_row_q);

    hcol   = body_col_q[head_ptr_q];
    hrow   = body_row_q[head_ptr_q];
    mv_col = hcol;
    mv_row = hrow;
    if (dir_q[0])      mv_col = hcol + 6'd1;
    else if (dir_q[1]) mv_col = hcol - 6'd1;
    else if (dir_q[3]) mv_row = hrow - 5'd1;
    else               mv_row = hrow + 5'd1;
    wall = (mv_col == 6'd0) || (mv_col == 6'(FRAME_X_SIZE - 1)) ||
           (mv_row == 5'd0) || (mv_row == 5'(FRAME_Y_SIZE - 1));
`ifdef SNAKE_WRAP_EN
    if (mv_col == 6'd0)                       mv_col = 6'(FRAME_X_SIZE - 2);
    else if (mv_col == 6'(FRAME_X_SIZE - 1))  mv_col = 6'd1;
    if (mv_row == 5'd0)                       mv_row = 5'(FRAME_Y_SIZE - 2);
    else if (mv_row == 5'(FRAME_Y_SIZE - 1))  mv_row = 5'd1;
`endif

    dir_ok = dir_valid && (dir_in != 4'd0) && ((dir_in & (dir_in - 4'd1)) == 4'd0) &&
             (dir_in != rev_dir(cdir_q));

    state_d   = state_q;
    cnt_d     = cnt_q + CNTW'(running && tick);
    dir_d     = dir_q;
    cdir_d    = cdir_q;
    mdir_d    = mdir_q;
    scan_d    = scan_q;
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    commit    = 1'b0;
    init      = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: if (cnt_q >= CNTW'(FRAMES_PER_STEP)) begin
        state_d = S_MOVE;
        cnt_d   = CNTW'(tick);
      end
      S_MOVE: begin
        nxt_col_d = mv_col;
        nxt_row_d = mv_row;
        mdir_d    = dir_q;
        scan_d    = '0;
`ifdef SNAKE_WRAP_EN
        state_d   = S_CHECK;
`else
        state_d   = wall ? S_DEAD : S_CHECK;
`endif
      end
      S_CHECK: begin
        if (hit) begin
          state_d = S_DEAD;
        end else if (scan_q == scan_last) begin
          commit  = 1'b1;
          state_d = S_RUN;
        end else begin
          scan_d = scan_q + 5'd1;
        end
      end
      S_DEAD: if (start) begin
        init    = 1'b1;
        state_d = S_RUN;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_DEAD && dir_ok) dir_d = dir_in;
    if (commit) cdir_d = mdir_q;

    pend_d = pend_q;
    if (commit) pend_d = 1'b0;
    if (grow && running) pend_d = 1'b1;

    len_d      = len_q;
    head_ptr_d = head_ptr_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    body_col_d = body_col_q;
    body_row_d = body_row_q;
    if (commit) begin
      head_ptr_d         = wr_ptr;
      body_col_d[wr_ptr] = nxt_col_q;
      body_row_d[wr_ptr] = nxt_row_q;
      hx_d               = pix_x(nxt_col_q);
      hy_d               = pix_y(nxt_row_q);
      if (pend_q && len_q < 5'(MAX_LEN)) len_d = len_q + 5'd1;
    end
    if (init) begin
      head_ptr_d = '0;
      len_d      = 5'(INIT_LEN);
      pend_d     = 1'b0;
      dir_d      = DIR_RIGHT;
      cdir_d     = DIR_RIGHT;
      hx_d       = pix_x(6'(START_COL));
      hy_d       = pix_y(5'(START_ROW));
      for (int i = 0; i < MAX_LEN; i++) begin
        body_col_d[i] = init_col(i);
        body_row_d[i] = init_row(i);
      end
    end

    step_d    = commit;
    seg_col_d = body_col_q[rd_ptr];
    seg_row_d = body_row_q[rd_ptr];
    seg_vld_d = {1'b0, seg_idx} < len_q;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      cnt_q      <= '0;
      dir_q      <= DIR_RIGHT;
      cdir_q     <= DIR_RIGHT;
      mdir_q     <= DIR_RIGHT;
      head_ptr_q <= '0;
      len_q      <= 5'(INIT_LEN);
      pend_q     <= 1'b0;
      scan_q     <= '0;
      nxt_col_q  <= '0;
      nxt_row_q  <= '0;
      hx_q       <= pix_x(6'(START_COL));
      hy_q       <= pix_y(5'(START_ROW));
      step_q     <= 1'b0;
      seg_col_q  <= '0;
      seg_row_q  <= '0;
      seg_vld_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_col_q[i] <= init_col(i);
        body_row_q[i] <= init_row(i);
      end
    end else begin
      state_q    <= state_d;
      vs_q       <= vsync_in;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      cdir_q     <= cdir_d;
      mdir_q     <= mdir_d;
      head_ptr_q <= head_ptr_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      scan_q     <= scan_d;
      nxt_col_q  <= nxt_col_d;
      nxt_row_q  <= nxt_row_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      step_q     <= step_d;
      seg_col_q  <= seg_col_d;
      seg_row_q  <= seg_row_d;
      seg_vld_q  <= seg_vld_d;
      body_col_q <= body_col_d;
      body_row_q <= body_row_d;
    end
  end

  assign seg_col    = seg_col_q;
  assign seg_row    = seg_row_q;
  assign seg_valid  = seg_vld_q;
  assign head_x     = hx_q;
  assign head_y     = hy_q;
  assign length     = len_q;
  assign alive      = running;
  assign game_over  = (state_q == S_DEAD);
  assign step_pulse = step_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Scoreboard bench for snake_ctrl: a cell-queue model of the snake predicts each
// step outcome; a monitor pops predictions on step_pulse / game_over rise.
module tb_snake_ctrl;
  logic        pclk = 1'b0;
  logic        rst, vsync_in, start, dir_valid, grow;
  logic [3:0]  dir_in, seg_idx;
  logic [5:0]  seg_col;
  logic [4:0]  seg_row;
  logic        seg_valid;
  logic [10:0] head_x, head_y;
  logic [4:0]  length;
  logic        alive, game_over, step_pulse;

  snake_ctrl dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start), .dir_in(dir_in),
    .dir_valid(dir_valid), .grow(grow), .seg_idx(seg_idx), .seg_col(seg_col),
    .seg_row(seg_row), .seg_valid(seg_valid), .head_x(head_x), .head_y(head_y),
    .length(length), .alive(alive), .game_over(game_over), .step_pulse(step_pulse)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit dead;
    int hx;
    int hy;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Model: body cells as a queue with the head at index 0; dirs 0=up 1=down 2=left 3=right.
  int mcol[$];
  int mrow[$];
  int mlen, ldir, cdir;
  bit mpend, mdead, mrun;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_init();
    mcol = {};
    mrow = {};
    for (int k = 0; k < 3; k++) begin
      mcol.push_back(20 - k);
      mrow.push_back(10);
    end
    mlen = 3; ldir = 3; cdir = 3; mpend = 0; mdead = 0;
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    int nc, nr, n;
    bit dead;
    nc = mcol[0] + ((ldir == 3) ? 1 : (ldir == 2) ? -1 : 0);
    nr = mrow[0] + ((ldir == 1) ? 1 : (ldir == 0) ? -1 : 0);
    dead = 0;
`ifdef SNAKE_WRAP_EN
    if (nc == 0) nc = 38; else if (nc == 39) nc = 1;
    if (nr == 0) nr = 18; else if (nr == 19) nr = 1;
`else
    if (nc == 0 || nc == 39 || nr == 0 || nr == 19) dead = 1;
`endif
    n = mpend ? mlen : mlen - 1;
    if (!dead)
      for (int k = 0; k < n; k++)
        if (mcol[k] == nc && mrow[k] == nr) dead = 1;
    if (dead) begin
      mdead = 1;
      mrun  = 0;
    end else begin
      mcol.push_front(nc);
      mrow.push_front(nr);
      if (mpend && mlen < 16) mlen++;
      mpend = 0;
      cdir  = ldir;
      if (mcol.size() > 16) begin
        void'(mcol.pop_back());
        void'(mrow.pop_back());
      end
    end
    e.dead = dead;
    e.hx   = 192 + 16 * mcol[0];
    e.hy   = 224 + 16 * mrow[0];
    e.len  = mlen;
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; grow = 0; dir_valid = 0; dir_in = 0; vsync_in = 0;
    sb.delete();
    model_init();
    mrun = 0;
    cyc(2);
    rst = 0;
    cyc(1);
  endtask

  task automatic do_start();
    start = 1;
    cyc(1);
    start = 0;
    model_init();
    mrun = 1;
  endtask

  task automatic fresh();
    do_reset();
    do_start();
  endtask

  task automatic req_dir(input logic [3:0] d, input bit v);
    dir_in = d; dir_valid = v;
    cyc(1);
    dir_valid = 0;
    if (mrun && v && $countones(d) == 1) begin
      int c;
      c = d[3] ? 0 : d[2] ? 1 : d[1] ? 2 : 3;
      if (c != (cdir ^ 1)) ldir = c;
    end
  endtask

  task automatic pulse_grow();
    grow = 1;
    cyc(1);
    grow = 0;
    if (mrun) mpend = 1;
  endtask

  task automatic pulse_vs();
    vsync_in = 1; cyc(2);
    vsync_in = 0; cyc(2);
  endtask

  task automatic do_step();
    int i;
    sb.push_back(model_step());
    repeat (8) pulse_vs();
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      cyc(1);
      i++;
    end
    if (sb.size() != 0) begin
      chk("step_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic seg_read(input int idx);
    seg_idx = 4'(idx);
    cyc(1);
    chk("seg_valid", int'(seg_valid), (idx < mlen) ? 1 : 0);
    if (idx < mlen) begin
      chk("seg_col", int'(seg_col), mcol[idx]);
      chk("seg_row", int'(seg_row), mrow[idx]);
    end
  endtask

  // Monitor: consumes one prediction per committed step or death.
  initial begin
    bit go_prev;
    exp_t e;
    go_prev = 0;
    forever begin
      @(negedge pclk);
      if (rst) begin
        go_prev = 0;
      end else begin
        if (step_pulse) begin
          if (sb.size() == 0) chk("unexpected_step", 1, 0);
          else begin
            e = sb.pop_front();
            chk("step_kind_dead", 0, int'(e.dead));
            chk("step_head_x", int'(head_x), e.hx);
            chk("step_head_y", int'(head_y), e.hy);
            chk("step_length", int'(length), e.len);
          end
        end
        if (game_over && !go_prev) begin
          if (sb.size() == 0) chk("unexpected_death", 1, 0);
          else begin
            e = sb.pop_front();
            chk("death_kind_dead", 1, int'(e.dead));
            chk("death_head_x", int'(head_x), e.hx);
            chk("death_head_y", int'(head_y), e.hy);
            chk("death_alive", int'(alive), 0);
          end
        end
        go_prev = game_over;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; grow = 0; dir_valid = 0; dir_in = 0; vsync_in = 0; seg_idx = 0;
    model_init();
    mrun = 0;
    cyc(2);
    chk("rst_head_x", int'(head_x), 512);
    chk("rst_head_y", int'(head_y), 384);
    chk("rst_length", int'(length), 3);
    chk("rst_alive", int'(alive), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_step_pulse", int'(step_pulse), 0);
    chk("rst_seg_valid", int'(seg_valid), 0);
    chk("rst_seg_col", int'(seg_col), 0);
    chk("rst_seg_row", int'(seg_row), 0);
    rst = 0;
    cyc(1);

    // Basic step and reads
    do_start();
    chk("start_alive", int'(alive), 1);
    do_step();
    chk("basic_head_x", int'(head_x), 528);
    chk("basic_head_y", int'(head_y), 384);
    seg_read(2);
    chk("basic_seg2_col", int'(seg_col), 19);

    // Direction latch / reverse rejection / non-one-hot
    req_dir(4'b0010, 1);
    do_step();
    chk("rev_reject_head_x", int'(head_x), 544);
    req_dir(4'b1000, 1);
    do_step();
    chk("up_head_y", int'(head_y), 368);
    req_dir(4'b0011, 1);
    do_step();
    chk("nonhot_head_y", int'(head_y), 352);

    // Growth keeps old tail readable
    pulse_grow();
    do_step();
    chk("grow_length", int'(length), 4);
    seg_read(3);

    // Randomised play
    for (int it = 0; it < 150; it++) begin
      if (mdead) do_start();
      if ($urandom % 3 == 0) req_dir(4'($urandom), ($urandom % 4) != 0);
      if ($urandom % 4 == 0) pulse_grow();
      do_step();
      if ($urandom % 3 == 0) seg_read($urandom_range(0, 15));
    end

    // Wall
    fresh();
    for (int s = 0; s < 19; s++) do_step();
`ifdef SNAKE_WRAP_EN
    chk("wrap_head_x", int'(head_x), 208);
    chk("wrap_alive", int'(alive), 1);
`else
    chk("wall_head_x", int'(head_x), 800);
    chk("wall_game_over", int'(game_over), 1);
    chk("wall_alive", int'(alive), 0);
`endif

    // Length saturation
    fresh();
    for (int s = 0; s < 13; s++) begin
      pulse_grow();
      do_step();
    end
    chk("sat_length16", int'(length), 16);
    pulse_grow();
    do_step();
    chk("sat_length_hold", int'(length), 16);
    seg_read(15);

    // Length 4: U-turn lands on the vacating tail
    fresh();
    pulse_grow(); do_step();
    req_dir(4'b1000, 1); do_step();
    req_dir(4'b0010, 1); do_step();
    req_dir(4'b0100, 1); do_step();
    chk("len4_uturn_alive", int'(alive), 1);
    chk("len4_uturn_game_over", int'(game_over), 0);

    // Length 5: same U-turn is fatal
    fresh();
    pulse_grow(); do_step();
    pulse_grow(); do_step();
    req_dir(4'b1000, 1); do_step();
    req_dir(4'b0010, 1); do_step();
    req_dir(4'b0100, 1); do_step();
    chk("len5_uturn_game_over", int'(game_over), 1);

    // Restart from DEAD
    do_start();
    chk("restart_length", int'(length), 3);
    chk("restart_head_x", int'(head_x), 512);
    chk("restart_head_y", int'(head_y), 384);
    chk("restart_alive", int'(alive), 1);
    chk("restart_game_over", int'(game_over), 0);
    do_step();
    chk("restart_step_head_x", int'(head_x), 528);

    // Reset in the middle of a step (during CHECK)
    fresh();
    pulse_grow(); do_step();
    repeat (7) pulse_vs();
    vsync_in = 1;
    cyc(3);
    rst = 1;
    sb.delete();
    model_init();
    mrun = 0;
    #1;
    chk("midrst_head_x", int'(head_x), 512);
    chk("midrst_head_y", int'(head_y), 384);
    chk("midrst_length", int'(length), 3);
    chk("midrst_alive", int'(alive), 0);
    chk("midrst_step_pulse", int'(step_pulse), 0);
    chk("midrst_seg_valid", int'(seg_valid), 0);
    cyc(2);
    vsync_in = 0;
    rst = 0;
    cyc(3);
    chk("midrst_idle_alive", int'(alive), 0);
    chk("midrst_idle_head_x", int'(head_x), 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
